operand_shift_mux: RTL and testbench

Registered, parametrised operand selector and bit-serial shifter for the modular-exponentiation datapath. It picks one of NUM_SRC source operands, the constant one, or zero, and captures the value on a load strobe. It then presents the value LSB-first, one bit per `shift_en` cycle, to the bit-serial Montgomery multiplier, with a parallel copy held for the parallel operand port. Busy/done flags let the exponentiation controller sequence loads without tracking bit counts itself.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/muxn_unit.sv | 38 +++
 rtl/operand_shift_mux.sv | 98 +++++++++
 tb/tb_operand_shift_mux.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation datapath.
// Contents:
//   SEL_ONE       - select code that picks the constant one
//   shift_state_t - state encoding of the operand shifter
//   sel_width(n)  - select width needed for n sources plus the constants
package rsa_pkg;

    localparam int SEL_ONE = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;

    // Codes: one, n sources, and at least one code left over for zero.
    function automatic int sel_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/muxn_unit.sv
// Combinational operand select decode.
// Ports:
//   src [NUM_SRC*WIDTH] - packed sources, source i at [i*WIDTH +: WIDTH]
//   sel [SEL_W]         - 0 = constant one, k = source k-1, other = zero
//   val [WIDTH]         - selected operand
module muxn_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         val
);

    logic [WIDTH-1:0] sel_val_s;

    // Decode the select code; unused codes fall through to zero.
    always_comb begin
        sel_val_s = '0;
        if (sel == SEL_W'(SEL_ONE)) begin
            sel_val_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (sel == SEL_W'(i + 1)) begin
                    sel_val_s = src[i*WIDTH +: WIDTH];
                end else begin
                    sel_val_s = sel_val_s;
                end
            end
        end
    end

    assign val = sel_val_s;

endmodule

// File: rtl/operand_shift_mux.sv
// Registered operand selector and LSB-first bit-serial shifter feeding the
// bit-serial Montgomery multiplier, with a held parallel copy.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   src, sel   - packed sources and select code (sampled on load)
//   load       - capture the selected operand (wins over shift_en)
//   shift_en   - consume one serial bit while busy
//   rotate     - 1: shifted-out bit re-enters at MSB, 0: MSB fills with 0
//   dout       - parallel copy of the last loaded operand
//   bit_o      - current serial bit (shift register bit 0)
//   busy       - serial bits remain
//   done       - one-cycle pulse after the last bit is consumed
module operand_shift_mux
    import rsa_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     load,
    input  logic                     shift_en,
    input  logic                     rotate,
    output logic [WIDTH-1:0]         dout,
    output logic                     bit_o,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sel_val_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] dout_r;
    logic [CNT_W-1:0] cnt_r;
    shift_state_t     state_r;
    logic             done_r;

    muxn_unit #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_muxn (
        .src (src),
        .sel (sel),
        .val (sel_val_s)
    );

    // Load/shift sequencer: load always restarts, shifts only count in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r  <= '0;
            dout_r  <= '0;
            cnt_r   <= '0;
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        sreg_r  <= sel_val_s;
                        dout_r  <= sel_val_s;
                        cnt_r   <= CNT_W'(WIDTH);
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        // Abort the current operand: no done for it.
                        sreg_r <= sel_val_s;
                        dout_r <= sel_val_s;
                        cnt_r  <= CNT_W'(WIDTH);
                    end else if (shift_en) begin
                        sreg_r <= {(rotate ? sreg_r[0] : 1'b0), sreg_r[WIDTH-1:1]};
                        cnt_r  <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dout  = dout_r;
    assign bit_o = sreg_r[0];
    assign busy  = (state_r == SHIFT);
    assign done  = done_r;

endmodule

// File: tb/tb_operand_shift_mux.sv
module tb_operand_shift_mux;

    localparam int WIDTH   = 8;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_SRC*WIDTH-1:0] src;
    logic [SEL_W-1:0]         sel;
    logic                     load;
    logic                     shift_en;
    logic                     rotate;
    logic [WIDTH-1:0]         dout;
    logic                     bit_o;
    logic                     busy;
    logic                     done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] sel;
        logic       rot;
        logic [7:0] exp_dout;
        logic [7:0] serial;     // bit n = n-th serial bit
        logic       final_bit;  // bit_o after all 8 shifts
    } vec_t;

    vec_t vecs[5];

    operand_shift_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src      (src),
        .sel      (sel),
        .load     (load),
        .shift_en (shift_en),
        .rotate   (rotate),
        .dout     (dout),
        .bit_o    (bit_o),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] s);
        sel  = s;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        int k;
        a5 = 8'hA5;

        vecs[0] = '{sel: 2'd0, rot: 1'b0, exp_dout: 8'h01, serial: 8'h01, final_bit: 1'b0};
        vecs[1] = '{sel: 2'd1, rot: 1'b1, exp_dout: 8'hA5, serial: 8'hA5, final_bit: 1'b1};
        vecs[2] = '{sel: 2'd2, rot: 1'b0, exp_dout: 8'h3C, serial: 8'h3C, final_bit: 1'b0};
        vecs[3] = '{sel: 2'd3, rot: 1'b0, exp_dout: 8'h00, serial: 8'h00, final_bit: 1'b0};
        vecs[4] = '{sel: 2'd2, rot: 1'b1, exp_dout: 8'h3C, serial: 8'h3C, final_bit: 1'b0};

        rst_n = 1'b0; src = {8'h3C, 8'hA5}; sel = 2'd0;
        load = 1'b0; shift_en = 1'b0; rotate = 1'b0;
        #12;
        check("reset_dout", dout, 0);
        check("reset_bit", bit_o, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        step();

        // Table: load, shift 8 with shift_en held, check serial stream and done.
        for (int v = 0; v < 5; v++) begin
            rotate = vecs[v].rot;
            do_load(vecs[v].sel);
            check("tbl_load_dout", dout, vecs[v].exp_dout);
            check("tbl_load_busy", busy, 1);
            for (int n = 0; n < 8; n++) begin
                check("tbl_serial_bit", bit_o, vecs[v].serial[n]);
                check("tbl_no_early_done", done, 0);
                shift_en = 1'b1;
                step();
            end
            shift_en = 1'b0;
            check("tbl_done", done, 1);
            check("tbl_busy_low", busy, 0);
            check("tbl_final_bit", bit_o, vecs[v].final_bit);
            check("tbl_dout_held", dout, vecs[v].exp_dout);
            step();
            check("tbl_done_pulse", done, 0);
        end

        // shift_en in IDLE: A5 rotated back leaves bit_o=1; must not move.
        shift_en = 1'b1;
        rotate = 1'b1;
        do_load(2'd1);
        for (int n = 0; n < 8; n++) step();
        shift_en = 1'b1;
        step();
        step();
        step();
        shift_en = 1'b0;
        check("idle_shift_bit", bit_o, 1);
        check("idle_shift_busy", busy, 0);
        check("idle_shift_done", done, 0);

        // Restart mid-operand: 3 shifts of A5 then reload with source 2.
        rotate = 1'b0;
        do_load(2'd1);
        shift_en = 1'b1;
        step(); step(); step();
        check("mid_bit3", bit_o, a5[3]);
        sel = 2'd2; load = 1'b1;
        step();
        load = 1'b0;
        check("restart_dout", dout, 8'h3C);
        check("restart_bit", bit_o, 0);
        check("restart_busy", busy, 1);
        for (int n = 0; n < 7; n++) begin
            check("restart_no_done", done, 0);
            step();
        end
        check("restart_busy7", busy, 1);
        check("restart_no_done7", done, 0);
        step();
        shift_en = 1'b0;
        check("restart_done", done, 1);
        step();

        // Load coincident with the final shift: no done.
        do_load(2'd1);
        shift_en = 1'b1;
        for (int n = 0; n < 7; n++) step();
        sel = 2'd2; load = 1'b1;
        step();
        load = 1'b0; shift_en = 1'b0;
        check("coinc_done", done, 0);
        check("coinc_busy", busy, 1);
        check("coinc_dout", dout, 8'h3C);
        step();
        check("coinc_done2", done, 0);

        // Gapped shift_en: bits advance only on asserted cycles.
        rotate = 1'b0;
        do_load(2'd1);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            check("gap_bit", bit_o, a5[k]);
            shift_en = ((c % 3) == 0);
            step();
            if ((c % 3) == 0) k++;
        end
        shift_en = 1'b0;
        check("gap_done", done, 1);
        check("gap_busy", busy, 0);
        step();

        // Asynchronous reset during shifting, then no resume without load.
        rotate = 1'b1;
        do_load(2'd1);
        shift_en = 1'b1;
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bit", bit_o, 0);
        check("arst_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        check("arst_no_resume_busy", busy, 0);
        check("arst_no_resume_bit", bit_o, 0);
        shift_en = 1'b0;
        do_load(2'd1);
        check("arst_reload_dout", dout, 8'hA5);
        check("arst_reload_busy", busy, 1);
        check("arst_reload_bit", bit_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
